// File: rtl/muldiv_unit_pkg.sv
// Shared op and FSM state encodings for the iterative
// multiply/divide unit.
package muldiv_defs;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10
    } state_e;

    function automatic logic op_signed(input logic [1:0] o);
        return (o == OP_MULT) || (o == OP_DIV);
    endfunction

    function automatic logic op_div(input logic [1:0] o);
        return (o == OP_DIV) || (o == OP_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply step or
// restoring divide step on unsigned magnitudes.
module muldiv_step
    import muldiv_defs::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             div_mode,
    input  logic [WIDTH-1:0] acc_hi,
    input  logic [WIDTH-1:0] acc_lo,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] next_hi,
    output logic [WIDTH-1:0] next_lo
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    logic           ge;

    always_comb begin
        sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : '0);
        shifted = {acc_hi, acc_lo[WIDTH-1]};
        diff    = shifted - {1'b0, operand};
        // partial remainder stays below 2*divisor, so bit WIDTH is the borrow
        ge      = ~diff[WIDTH];
        if (div_mode) begin
            next_hi = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
            next_lo = {acc_lo[WIDTH-2:0], ge};
        end else begin
            next_hi = sum[WIDTH:1];
            next_lo = {sum[0], acc_lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers,
// one result bit per cycle, start/busy/done handshake.
module muldiv_unit
    import muldiv_defs::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_e             state, state_next;
    logic [CNT_W-1:0]   cnt;
    logic               div_q;
    logic               neg_q;
    logic               neg_r;
    logic               dz_q;
    logic [WIDTH-1:0]   a_raw;
    logic [WIDTH-1:0]   operand;
    logic [WIDTH-1:0]   acc_hi, acc_lo;
    logic [WIDTH-1:0]   step_hi, step_lo;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic               sa, sb;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   fix_hi, fix_lo;
    logic               last;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .div_mode (div_q),
        .acc_hi   (acc_hi),
        .acc_lo   (acc_lo),
        .operand  (operand),
        .next_hi  (step_hi),
        .next_lo  (step_lo)
    );

    assign busy = (state != S_IDLE);
    assign last = (cnt == CNT_W'(WIDTH - 1));

    always_comb begin
        sa    = op_signed(op) & a[WIDTH-1];
        sb    = op_signed(op) & b[WIDTH-1];
        mag_a = sa ? -a : a;
        mag_b = sb ? -b : b;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE: if (start) state_next = S_CALC;
            S_CALC: if (last) state_next = S_FIX;
            S_FIX:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        prod   = {acc_hi, acc_lo};
        fix_hi = acc_hi;
        fix_lo = acc_lo;
        if (!div_q) begin
            if (neg_q) prod = -prod;
            fix_hi = prod[2*WIDTH-1:WIDTH];
            fix_lo = prod[WIDTH-1:0];
        end else if (dz_q) begin
            fix_hi = a_raw;
            fix_lo = '1;
        end else begin
            fix_hi = neg_r ? -acc_hi : acc_hi;
            fix_lo = neg_q ? -acc_lo : acc_lo;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            div_q    <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            dz_q     <= 1'b0;
            a_raw    <= '0;
            operand  <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                    if (start) begin
                        cnt     <= '0;
                        div_q   <= op_div(op);
                        neg_q   <= sa ^ sb;
                        neg_r   <= sa;
                        dz_q    <= op_div(op) & (b == '0);
                        a_raw   <= a;
                        acc_hi  <= '0;
                        // multiplier or dividend shifts through acc_lo
                        acc_lo  <= op_div(op) ? mag_a : mag_b;
                        operand <= op_div(op) ? mag_b : mag_a;
                    end
                end
                S_CALC: begin
                    cnt    <= cnt + 1'b1;
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                end
                S_FIX: begin
                    hi       <= fix_hi;
                    lo       <= fix_lo;
                    done     <= 1'b1;
                    div_zero <= dz_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a, b, wdata;
    logic        hi_we, lo_we;
    logic        busy, done, div_zero;
    logic [31:0] hi, lo;

    int npass = 0;
    int ntotal = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .hi_we    (hi_we),
        .lo_we    (lo_we),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        ntotal++;
        if (got === exp) npass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Called at a negedge; start is sampled at the next posedge (edge E).
    task automatic launch(input logic [1:0] o,
                          input logic [31:0] x,
                          input logic [31:0] y);
        start = 1'b1;
        op = o;
        a = x;
        b = y;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Returns in the done cycle; lat counts edges after E.
    task automatic wait_done(input string tag, input bit poke);
        int c;
        int bc;
        logic [31:0] ph, pl;
        c = 0;
        bc = 0;
        ph = hi;
        pl = lo;
        while (!done && c < 100) begin
            if (busy) bc++;
            if (poke && c == 5) begin
                start = 1'b1;
                hi_we = 1'b1;
                wdata = 32'h1234;
            end else begin
                start = 1'b0;
                hi_we = 1'b0;
            end
            if (poke && c == 7) begin
                check({tag, "_hold_hi"}, 64'(hi), 64'(ph));
                check({tag, "_hold_lo"}, 64'(lo), 64'(pl));
            end
            @(negedge clk);
            c++;
        end
        check({tag, "_lat"}, 64'(c), 64'd33);
        check({tag, "_busycnt"}, 64'(bc), 64'd33);
        check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    endtask

    task automatic run(input string tag, input logic [1:0] o,
                       input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] ehi, input logic [31:0] elo,
                       input logic edz, input bit poke);
        launch(o, x, y);
        wait_done(tag, poke);
        check({tag, "_hi"}, 64'(hi), 64'(ehi));
        check({tag, "_lo"}, 64'(lo), 64'(elo));
        check({tag, "_dz"}, 64'(div_zero), 64'(edz));
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        op = 2'b00;
        a = '0;
        b = '0;
        wdata = '0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        run("mult_neg", 2'b00, 32'hFFFFFFFD, 32'h7,
            32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 1'b0);
        @(negedge clk);
        check("done_pulse", 64'(done), 64'd0);
        run("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF,
            32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0);
        run("mult_m1", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF,
            32'h0, 32'h1, 1'b0, 1'b0);
        run("div_neg", 2'b10, 32'hFFFFFFF9, 32'h2,
            32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0);
        run("divu_7_2", 2'b11, 32'h7, 32'h2,
            32'h1, 32'h3, 1'b0, 1'b0);
        run("div_7_m2", 2'b10, 32'h7, 32'hFFFFFFFE,
            32'h1, 32'hFFFFFFFD, 1'b0, 1'b0);
        run("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF,
            32'h0, 32'h80000000, 1'b0, 1'b0);
        run("divu_z", 2'b11, 32'h5, 32'h0,
            32'h5, 32'hFFFFFFFF, 1'b1, 1'b0);
        @(negedge clk);
        check("dz_pulse", 64'(div_zero), 64'd0);
        run("div_z", 2'b10, 32'hFFFFFFF9, 32'h0,
            32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1, 1'b0);

        run("poke", 2'b01, 32'h00010000, 32'h00010000,
            32'h1, 32'h0, 1'b0, 1'b1);
        run("b2b", 2'b00, 32'h3, 32'h5,
            32'h0, 32'hF, 1'b0, 1'b0);

        lo_we = 1'b1;
        wdata = 32'hABCD;
        @(negedge clk);
        lo_we = 1'b0;
        check("mtlo_lo", 64'(lo), 64'hABCD);
        check("mtlo_hi", 64'(hi), 64'h0);

        launch(2'b10, 32'h64, 32'h7);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_hilo", {hi, lo}, 64'd0);
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 40; i++) begin
                if (done) seen++;
                @(negedge clk);
            end
            check("abort_nodone", 64'(seen), 64'd0);
        end
        run("multu_3_4", 2'b01, 32'h3, 32'h4,
            32'h0, 32'hC, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative multiply/divide unit with architectural HI/LO registers, parametrised in operand width. It serves MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO for the multi-cycle CPU. It sits beside the ALU and is driven by the controller, which stalls on busy and advances on done. One result bit is produced per cycle, with a start/busy/done handshake.

Parameters:
WIDTH, 32, operand/HI/LO width; even, >= 4
CNT_W, $clog2(WIDTH)+1, iteration counter width (localparam, derived)

Ports:
clk       input   1      clock; all state updates on rising edge
rst       input   1      synchronous, active-high reset
start     input   1      launch operation; sampled only in IDLE
op        input   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
a         input   WIDTH  Rs value: multiplicand or dividend
b         input   WIDTH  Rt value: multiplier or divisor
hi_we     input   1      MTHI write strobe
lo_we     input   1      MTLO write strobe
wdata     input   WIDTH  MTHI/MTLO data
busy      output  1      high while state != IDLE
done      output  1      one-cycle pulse; HI/LO hold the new result
div_zero  output  1      pulses with done when a DIV/DIVU had b == 0
hi        output  WIDTH  HI register (MFHI source)
lo        output  WIDTH  LO register (MFLO source)

Behaviour:
- Reset (rst=1 at an edge): state IDLE; hi=0, lo=0, busy=0, done=0, div_zero=0; counter and working registers cleared.
- Reset mid-operation aborts the operation. No done pulse is produced and HI/LO are cleared.
- FSM states and transitions:
  - IDLE -> CALC when start=1. op, a and b are latched; operand magnitudes and result signs are captured (signed ops only); counter=0.
  - CALC performs one iteration per edge and increments the counter. It moves to FIX at the edge where the counter reaches WIDTH.
  - FIX applies sign correction and writes HI/LO. It sets done=1, and div_zero if applicable, then returns to IDLE.
- Timing: start sampled at edge E.
  - Iterations happen at edges E+1..E+WIDTH.
  - HI/LO are written at edge E+WIDTH+1.
  - done is high for exactly the one cycle after that edge.
  - busy is high from E until edge E+WIDTH+1. busy=0 in the same cycle that done=1.
- Multiply: shift-add on magnitudes. {HI,LO} = full 2*WIDTH-bit product; signed for MULT, unsigned for MULTU. Never overflows.
- Divide: restoring division on magnitudes. LO = quotient, truncated toward zero. HI = remainder, with the sign of the dividend.
- Signed most-negative / -1: LO = 1 followed by WIDTH-1 zeros, HI = 0. This falls out of the magnitude algorithm and needs no special case.
- Divide by zero:
  - LO = all ones; HI = a (raw input).
  - Same latency as a normal divide.
  - div_zero=1 in the done cycle; 0 otherwise.
- start while busy is ignored. start in the done cycle (IDLE) is accepted, giving back-to-back operation.
- hi_we/lo_we:
  - In IDLE they write wdata at the edge; both may write in the same cycle.
  - While busy they are ignored.
  - Simultaneous start and hi_we/lo_we in IDLE: the write takes effect, the op launches, and the op's result later overwrites.
- hi/lo change only on reset, an idle MT write, or the FIX edge. They are stable throughout CALC.
- done and div_zero are registered outputs.

Decomposition:
- Shared header/package muldiv_defs: op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU) and FSM state encodings (S_IDLE, S_CALC, S_FIX).
- One natural sub-module, muldiv_step: a combinational single iteration.
  - Multiply mode: conditional add of the multiplicand plus a shift.
  - Divide mode: trial subtract, restore, and quotient bit.
  - muldiv_unit keeps the FSM, counter, sign logic and HI/LO.

Test Plan:
- MULT a=FFFFFFFD b=00000007 -> done exactly 33 cycles after start edge; HI=FFFFFFFF LO=FFFFFFEB; busy high 33 cycles; div_zero=0.
- MULTU a=FFFFFFFF b=FFFFFFFF -> HI=FFFFFFFE LO=00000001; MULT on the same operands -> HI=00000000 LO=00000001.
- DIV a=FFFFFFF9 b=00000002 -> LO=FFFFFFFD HI=FFFFFFFF; DIVU a=7 b=2 -> LO=3 HI=1; DIV a=7 b=FFFFFFFE -> LO=FFFFFFFD HI=1.
- DIV a=80000000 b=FFFFFFFF -> LO=80000000 HI=0; DIVU a=5 b=0 -> LO=FFFFFFFF HI=5 with div_zero=1 in the done cycle only.
- Handshake/MT checks, all followed by correct results:
  - start re-pulsed and hi_we=1 wdata=1234 mid-CALC -> ignored, HI/LO unchanged until FIX.
  - start in the done cycle -> second op accepted immediately.
  - lo_we in IDLE with wdata=ABCD -> lo=ABCD next cycle.
- rst asserted 10 cycles into a DIV -> next cycle busy=0, done=0, hi=lo=0, no later done. A following MULTU 3*4 gives LO=C HI=0.
